wb_timer_multi: RTL

Parametrised multi-channel Wishbone timer; successor to the single-counter timer peripheral on the RV32I Wishbone bus. Holds NUM_CH independent up-counters, each with its own prescaler, compare value, one-shot/periodic mode and interrupt enable. The Wishbone slave handshake is built in, so no separate adapter is needed. Exports live counter values and one level-sensitive interrupt line.

---
 rtl/wb_timer_multi.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/wb_timer_multi.sv
// Multi-channel Wishbone timer: NUM_CH prescaled up-counters with compare,
// one-shot/periodic modes, write-1-to-clear pending flags and one shared irq.
module wb_timer_multi #(
   parameter int NUM_CH  = 4,
   parameter int CNT_W   = 32,
   parameter int PRESC_W = 16
) (
   input  logic                    clk_i,
   input  logic                    rst_n_i,
   input  logic [31:0]             wb_adr_i,
   input  logic [31:0]             wb_dat_i,
   input  logic [3:0]              wb_sel_i,
   input  logic                    wb_we_i,
   input  logic                    wb_cyc_i,
   input  logic                    wb_stb_i,
   output logic [31:0]             wb_dat_o,
   output logic                    wb_ack_o,
   output logic                    irq_o,
   output logic [NUM_CH*CNT_W-1:0] timer_value_o
);

   localparam logic [31:0] INFO = {8'(NUM_CH), 8'(CNT_W), 16'h0000};

   logic [NUM_CH-1:0]  en_q, per_q, ie_q, pending_q;
   logic [PRESC_W-1:0] presc_q [NUM_CH];
   logic [PRESC_W-1:0] pcnt_q  [NUM_CH];
   logic [CNT_W-1:0]   cmp_q   [NUM_CH];
   logic [CNT_W-1:0]   cnt_q   [NUM_CH];

   logic               req, wr, glob;
   logic [2:0]         ch_sel;
   logic [1:0]         reg_sel;
   logic [NUM_CH-1:0]  ch_wr, ctrl_wr, tick, hit, set_pend, clr_pend;
   logic [PRESC_W-1:0] presc_new [NUM_CH];
   logic [CNT_W-1:0]   cmp_new   [NUM_CH];
   logic [CNT_W-1:0]   cnt_new   [NUM_CH];
   logic [31:0]        rdata;
   logic               unused_adr;

   // Handshake: a request (cyc & stb) is accepted on any edge where ack is low;
   // that edge commits writes, registers read data and raises ack for one cycle.
   assign req     = wb_cyc_i & wb_stb_i & ~wb_ack_o;
   assign wr      = req & wb_we_i;
   assign glob    = wb_adr_i[7];
   assign ch_sel  = wb_adr_i[6:4];
   assign reg_sel = wb_adr_i[3:2];
   assign unused_adr = ^{wb_adr_i[31:8], wb_adr_i[1:0]};

   function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  sel);
      logic [31:0] r;
      for (int b = 0; b < 4; b++) r[8*b +: 8] = sel[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
      return r;
   endfunction

   always_comb begin
      for (int c = 0; c < NUM_CH; c++) begin
         ch_wr[c]     = wr & ~glob & (ch_sel == 3'(c));
         ctrl_wr[c]   = ch_wr[c] & (reg_sel == 2'd0) & wb_sel_i[0];
         tick[c]      = en_q[c] & (pcnt_q[c] == presc_q[c]);
         hit[c]       = cnt_q[c] == cmp_q[c];
         set_pend[c]  = tick[c] & hit[c];
         presc_new[c] = PRESC_W'(merge_bytes(32'(presc_q[c]), wb_dat_i, wb_sel_i));
         cmp_new[c]   = CNT_W'(merge_bytes(32'(cmp_q[c]), wb_dat_i, wb_sel_i));
         cnt_new[c]   = CNT_W'(merge_bytes(32'(cnt_q[c]), wb_dat_i, wb_sel_i));
      end
      clr_pend = '0;
      if (wr && glob && wb_adr_i[6:2] == 5'd0 && wb_sel_i[0])
         clr_pend = wb_dat_i[NUM_CH-1:0];
   end

   always_comb begin
      rdata = '0;
      if (glob) begin
         if (wb_adr_i[6:2] == 5'd0)      rdata[NUM_CH-1:0] = pending_q;
         else if (wb_adr_i[6:2] == 5'd1) rdata = INFO;
      end else begin
         for (int c = 0; c < NUM_CH; c++) begin
            if (ch_sel == 3'(c)) begin
               case (reg_sel)
                  2'd0:    rdata = {29'd0, ie_q[c], per_q[c], en_q[c]};
                  2'd1:    rdata = 32'(presc_q[c]);
                  2'd2:    rdata = 32'(cmp_q[c]);
                  default: rdata = 32'(cnt_q[c]);
               endcase
            end
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         wb_ack_o <= 1'b0;
         wb_dat_o <= '0;
      end else begin
         wb_ack_o <= req;
         wb_dat_o <= (req && !wb_we_i) ? rdata : '0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         en_q      <= '0;
         per_q     <= '0;
         ie_q      <= '0;
         pending_q <= '0;
         for (int c = 0; c < NUM_CH; c++) begin
            presc_q[c] <= '0;
            pcnt_q[c]  <= '0;
            cmp_q[c]   <= '0;
            cnt_q[c]   <= '0;
         end
      end else begin
         // A same-edge tick set beats the write-1-to-clear.
         pending_q <= (pending_q & ~clr_pend) | set_pend;
         for (int c = 0; c < NUM_CH; c++) begin
            if (ctrl_wr[c]) begin
               en_q[c]  <= wb_dat_i[0];
               per_q[c] <= wb_dat_i[1];
               ie_q[c]  <= wb_dat_i[2];
            end else if (set_pend[c] && !per_q[c]) begin
               en_q[c] <= 1'b0;
            end
            if (ch_wr[c] && reg_sel == 2'd1) presc_q[c] <= presc_new[c];
            if (ch_wr[c] && reg_sel == 2'd2) cmp_q[c]   <= cmp_new[c];
            if (ch_wr[c] && reg_sel == 2'd3) begin
               cnt_q[c] <= cnt_new[c];
            end else if (tick[c]) begin
               if (!hit[c])      cnt_q[c] <= cnt_q[c] + CNT_W'(1);
               else if (per_q[c]) cnt_q[c] <= '0;
            end
            // Restart the prescale phase on a counter load or an enable edge.
            if ((ch_wr[c] && reg_sel == 2'd3) || (ctrl_wr[c] && wb_dat_i[0] && !en_q[c]))
               pcnt_q[c] <= '0;
            else if (tick[c])
               pcnt_q[c] <= '0;
            else if (en_q[c])
               pcnt_q[c] <= pcnt_q[c] + PRESC_W'(1);
         end
      end
   end

   assign irq_o = |(pending_q & ie_q);

   for (genvar c = 0; c < NUM_CH; c++) begin : g_tv
      assign timer_value_o[c*CNT_W +: CNT_W] = cnt_q[c];
   end

endmodule
